// File: rtl/debounce_sync.sv
// debounce_sync: 2-flop synchronizer, debounce FSM with stability counter, edge pulses and bounce counter
module debounce_sync #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       d_raw,
    output logic       d_clean,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic       busy,
    output logic [7:0] bounce_count
);
    typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic s1_q, s2_q;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic d_clean_q, d_clean_d, rise_q, rise_d, fall_q, fall_d, busy_q, busy_d, abort;
    logic [7:0] bounce_q, bounce_d;
    // two-stage synchronizer; s2_q is the only view of d_raw the FSM gets
    always_ff @(posedge clock) begin
        s1_q <= reset ? 1'b0 : d_raw;
        s2_q <= reset ? 1'b0 : s1_q;
    end
    // next-state logic: WAIT states count consecutive samples at the new level
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        d_clean_d = d_clean_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        abort     = 1'b0;
        case (state_q)
            STABLE_LO: begin
                state_d = s2_q ? WAIT_HI : STABLE_LO;
                cnt_d   = s2_q ? CNT_W'(1) : '0;
            end
            WAIT_HI: begin
                if (!s2_q) begin
                    state_d = STABLE_LO;
                    abort   = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = STABLE_HI;
                    d_clean_d = 1'b1;
                    rise_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE_HI: begin
                state_d = s2_q ? STABLE_HI : WAIT_LO;
                cnt_d   = s2_q ? '0 : CNT_W'(1);
            end
            WAIT_LO: begin
                if (s2_q) begin
                    state_d = STABLE_HI;
                    abort   = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = STABLE_LO;
                    d_clean_d = 1'b0;
                    fall_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = STABLE_LO;
                d_clean_d = 1'b0;
            end
        endcase
        busy_d   = (state_d == WAIT_HI) || (state_d == WAIT_LO);
        bounce_d = (abort && bounce_q != 8'hFF) ? bounce_q + 8'd1 : bounce_q;
    end
    // FSM and output registers; reset overrides any transition and suppresses pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= STABLE_LO;
            cnt_q     <= '0;
            d_clean_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            busy_q    <= 1'b0;
            bounce_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            d_clean_q <= d_clean_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            busy_q    <= busy_d;
            bounce_q  <= bounce_d;
        end
    end
    assign d_clean      = d_clean_q;
    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign busy         = busy_q;
    assign bounce_count = bounce_q;
endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: directed self-checking bench for debounce_sync with DEBOUNCE_CYCLES=4
module tb_debounce_sync;
    logic clock = 1'b0;
    logic reset, d_raw, d_clean, rise_pulse, fall_pulse, busy;
    logic [7:0] bounce_count;
    int checks = 0;
    int errors = 0;

    debounce_sync #(.DEBOUNCE_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .d_raw(d_raw), .d_clean(d_clean),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .busy(busy),
        .bounce_count(bounce_count)
    );

    always #5 clock = ~clock;

    // inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        d_raw = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        d_raw = 1'b1;
        tick();
        tick();
        checks++;
        if ({d_clean, rise_pulse, fall_pulse, busy, bounce_count} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got %b%b%b%b %h exp all zero", d_clean, rise_pulse, fall_pulse, busy, bounce_count);
        end
    endtask

    task automatic test_steady_high();
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (d_clean !== (k >= 6)) begin
                errors++;
                $display("FAIL steady_d_clean k=%0d got %b exp %b", k, d_clean, k >= 6);
            end
            checks++;
            if (rise_pulse !== (k == 6)) begin
                errors++;
                $display("FAIL steady_rise k=%0d got %b exp %b", k, rise_pulse, k == 6);
            end
            checks++;
            if (busy !== (k >= 3 && k <= 5)) begin
                errors++;
                $display("FAIL steady_busy k=%0d got %b exp %b", k, busy, k >= 3 && k <= 5);
            end
        end
        checks++;
        if (bounce_count !== 8'd0) begin
            errors++;
            $display("FAIL steady_bounce got %0d exp 0", bounce_count);
        end
    endtask

    task automatic test_full_cycle();
        d_raw = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (fall_pulse !== (k == 6)) begin
                errors++;
                $display("FAIL cycle_fall k=%0d got %b exp %b", k, fall_pulse, k == 6);
            end
            checks++;
            if (d_clean !== (k < 6)) begin
                errors++;
                $display("FAIL cycle_d_clean k=%0d got %b exp %b", k, d_clean, k < 6);
            end
            checks++;
            if (rise_pulse !== 1'b0) begin
                errors++;
                $display("FAIL cycle_rise k=%0d got %b exp 0", k, rise_pulse);
            end
        end
    endtask

    task automatic test_short_glitch();
        d_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 2) d_raw = 1'b0;
            checks++;
            if ({d_clean, rise_pulse, fall_pulse} !== 3'b000) begin
                errors++;
                $display("FAIL glitch_outputs k=%0d got %b%b%b exp 000", k, d_clean, rise_pulse, fall_pulse);
            end
            checks++;
            if (busy !== (k == 3 || k == 4)) begin
                errors++;
                $display("FAIL glitch_busy k=%0d got %b exp %b", k, busy, k == 3 || k == 4);
            end
        end
        checks++;
        if (bounce_count !== 8'd1) begin
            errors++;
            $display("FAIL glitch_bounce got %0d exp 1", bounce_count);
        end
    endtask

    task automatic test_bounce_train();
        logic [4:0] pattern = 5'b10101;
        int rises = 0;
        apply_reset();
        tick();
        for (int i = 4; i >= 0; i--) begin
            d_raw = pattern[i];
            tick();
            rises += int'(rise_pulse);
            checks++;
            if (d_clean !== 1'b0) begin
                errors++;
                $display("FAIL train_early_d_clean i=%0d got %b exp 0", i, d_clean);
            end
        end
        for (int k = 2; k <= 9; k++) begin
            tick();
            rises += int'(rise_pulse);
            checks++;
            if (d_clean !== (k >= 6)) begin
                errors++;
                $display("FAIL train_d_clean k=%0d got %b exp %b", k, d_clean, k >= 6);
            end
        end
        checks++;
        if (rises !== 1) begin
            errors++;
            $display("FAIL train_rise_count got %0d exp 1", rises);
        end
        checks++;
        if (bounce_count !== 8'd2) begin
            errors++;
            $display("FAIL train_bounce got %0d exp 2", bounce_count);
        end
    endtask

    task automatic test_reset_mid();
        int falls = 0;
        reset = 1'b1;
        d_raw = 1'b0;
        tick();
        checks++;
        if ({d_clean, rise_pulse, fall_pulse, busy, bounce_count} !== 12'h000) begin
            errors++;
            $display("FAIL reset_hi_outputs got %b%b%b%b %h exp all zero", d_clean, rise_pulse, fall_pulse, busy, bounce_count);
        end
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            falls += int'(fall_pulse);
        end
        d_raw = 1'b1;
        for (int k = 1; k <= 4; k++) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_wait_busy got %b exp 1", busy);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({d_clean, rise_pulse, fall_pulse, busy, bounce_count} !== 12'h000) begin
            errors++;
            $display("FAIL reset_wait_outputs got %b%b%b%b %h exp all zero", d_clean, rise_pulse, fall_pulse, busy, bounce_count);
        end
        reset = 1'b0;
        d_raw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            falls += int'(fall_pulse);
            checks++;
            if ({d_clean, rise_pulse, bounce_count} !== 10'h000) begin
                errors++;
                $display("FAIL reset_after k=%0d got %b%b %h exp all zero", k, d_clean, rise_pulse, bounce_count);
            end
        end
        checks++;
        if (falls !== 0) begin
            errors++;
            $display("FAIL reset_fall_count got %0d exp 0", falls);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        tick();
        for (int g = 1; g <= 300; g++) begin
            d_raw = 1'b1;
            tick();
            tick();
            d_raw = 1'b0;
            for (int k = 0; k < 4; k++) tick();
            checks++;
            if (bounce_count !== 8'((g > 255) ? 255 : g)) begin
                errors++;
                $display("FAIL sat_bounce g=%0d got %0d exp %0d", g, bounce_count, (g > 255) ? 255 : g);
            end
            checks++;
            if (d_clean !== 1'b0) begin
                errors++;
                $display("FAIL sat_d_clean g=%0d got %b exp 0", g, d_clean);
            end
        end
    endtask

    initial begin
        test_reset();
        test_steady_high();
        test_full_cycle();
        test_short_glitch();
        test_bounce_train();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
